// File: rtl/gpu_clut_cache_ctrl.sv
// CLUT tag cache and palette-load sequencer for the texture path.
// Ports: request (clut/depth) in, done (slot/hit) out, packet fetch out, busy.
module gpu_clut_cache_ctrl #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2,
  parameter int PKT_8BPP  = 16
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_flush,
  input  logic              i_reqValid,
  output logic              o_reqReady,
  input  logic [14:0]       i_reqClut,
  input  logic              i_req8BPP,
  output logic              o_doneValid,
  output logic [SLOT_W-1:0] o_doneSlot,
  output logic              o_doneHit,
  output logic              o_memReqValid,
  input  logic              i_memReqReady,
  output logic [14:0]       o_memAdr,
  output logic [3:0]        o_memBlock,
  output logic [SLOT_W-1:0] o_memSlot,
  input  logic              i_pktDone,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [NUM_SLOTS-1:0] vld_q, vld_d;
  logic [NUM_SLOTS-1:0] tag_is8_q, tag_is8_d;
  logic [14:0]          tag_clut_q [NUM_SLOTS];
  logic [14:0]          tag_clut_d [NUM_SLOTS];

  logic [SLOT_W-1:0] rr_q, rr_d;
  logic [14:0]       clut_q, clut_d;
  logic              is8_q, is8_d;
  logic [SLOT_W-1:0] victim_q, victim_d;
  logic [4:0]        rem_q, rem_d;
  logic              fseen_q, fseen_d;
  logic              dvld_q, dvld_d;
  logic              dhit_q, dhit_d;
  logic [SLOT_W-1:0] dslot_q, dslot_d;

  logic [NUM_SLOTS-1:0] live;
  logic [NUM_SLOTS-1:0] hit_vec;
  logic [NUM_SLOTS-1:0] upg_vec;
  logic [NUM_SLOTS-1:0] free_vec;
  logic [3:0]           blk;

  function automatic logic [SLOT_W-1:0] lowest(
    input logic [NUM_SLOTS-1:0] v
  );
    lowest = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (v[i]) lowest = SLOT_W'(i);
    end
  endfunction

  // A flush in the accept cycle wins, so lookup sees empty tags.
  always_comb begin
    live     = i_flush ? '0 : vld_q;
    hit_vec  = '0;
    upg_vec  = '0;
    free_vec = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit_vec[i]  = live[i]
                  & (tag_clut_q[i] == i_reqClut)
                  & (tag_is8_q[i] | ~i_req8BPP);
      upg_vec[i]  = live[i]
                  & (tag_clut_q[i] == i_reqClut)
                  & ~tag_is8_q[i];
      free_vec[i] = ~live[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    vld_d      = vld_q;
    tag_is8_d  = tag_is8_q;
    tag_clut_d = tag_clut_q;
    rr_d       = rr_q;
    clut_d     = clut_q;
    is8_d      = is8_q;
    victim_d   = victim_q;
    rem_d      = rem_q;
    fseen_d    = fseen_q;
    dvld_d     = 1'b0;
    dhit_d     = 1'b0;
    dslot_d    = '0;

    if (i_flush) begin
      vld_d = '0;
      rr_d  = '0;
      if (state_q != IDLE) fseen_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (i_reqValid) begin
          if (|hit_vec) begin
            dvld_d  = 1'b1;
            dhit_d  = 1'b1;
            dslot_d = lowest(hit_vec);
          end else begin
            if (|upg_vec) begin
              victim_d = lowest(upg_vec);
            end else if (|free_vec) begin
              victim_d = lowest(free_vec);
            end else begin
              victim_d = rr_q;
              rr_d     = rr_q + 1'b1;
            end
            vld_d[victim_d] = 1'b0;
            clut_d  = i_reqClut;
            is8_d   = i_req8BPP;
            rem_d   = i_req8BPP ? 5'(PKT_8BPP) : 5'd1;
            fseen_d = 1'b0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (i_memReqReady) state_d = WAIT;
      end
      WAIT: begin
        if (i_pktDone) begin
          rem_d   = rem_q - 5'd1;
          state_d = (rem_q == 5'd1) ? DONE : ISSUE;
        end
      end
      DONE: begin
        vld_d[victim_q]      = ~(fseen_q | i_flush);
        tag_clut_d[victim_q] = clut_q;
        tag_is8_d[victim_q]  = is8_q;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q  <= IDLE;
      vld_q    <= '0;
      rr_q     <= '0;
      clut_q   <= '0;
      is8_q    <= 1'b0;
      victim_q <= '0;
      rem_q    <= '0;
      fseen_q  <= 1'b0;
      dvld_q   <= 1'b0;
      dhit_q   <= 1'b0;
      dslot_q  <= '0;
    end else begin
      state_q  <= state_d;
      vld_q    <= vld_d;
      rr_q     <= rr_d;
      clut_q   <= clut_d;
      is8_q    <= is8_d;
      victim_q <= victim_d;
      rem_q    <= rem_d;
      fseen_q  <= fseen_d;
      dvld_q   <= dvld_d;
      dhit_q   <= dhit_d;
      dslot_q  <= dslot_d;
    end
  end

  // Tag payload is qualified by vld_q, so it needs no reset.
  always_ff @(posedge i_clk) begin
    tag_clut_q <= tag_clut_d;
    tag_is8_q  <= tag_is8_d;
  end

  // Block = remaining-1; 16 wraps to 0 in 4 bits, giving 15.
  assign blk = rem_q[3:0] - 4'd1;

  assign o_reqReady    = (state_q == IDLE);
  assign o_busy        = (state_q != IDLE);
  assign o_memReqValid = (state_q == ISSUE);
  assign o_memBlock    = o_memReqValid ? blk : 4'd0;
  assign o_memSlot     = o_memReqValid ? victim_q : '0;
  // X wraps within the 64-entry row; Y is never carried.
  assign o_memAdr      = o_memReqValid
                       ? {clut_q[14:6], clut_q[5:0] + {2'b00, blk}}
                       : 15'd0;
  assign o_doneValid   = dvld_q | (state_q == DONE);
  assign o_doneSlot    = (state_q == DONE) ? victim_q : dslot_q;
  assign o_doneHit     = dhit_q;

endmodule

// File: doc/gpu_clut_cache_ctrl.md
Name: gpu_clut_cache_ctrl

Overview:
Multi-slot CLUT tag cache and palette-load sequencer for the texture path.
- Tracks NUM_SLOTS cached palettes, each tagged by 15-bit CLUT address and depth.
- On a primitive's CLUT request it reports a hit slot immediately. On a miss it allocates a slot and issues 1 (4bpp) or 16 (8bpp) 16-entry packet loads to the VRAM fetch unit.
- Sits between command decode and the CLUT cache RAM; the returned slot index selects the palette bank.

Parameters:
NUM_SLOTS, 4, number of cached palettes; power of two, 2..16.
SLOT_W, 2, width of slot index; must equal log2(NUM_SLOTS).
PKT_8BPP, 16, packets per 8bpp palette; 2..16.

Ports:
i_clk  in  1  clock
i_nrst  in  1  synchronous active-low reset
i_flush  in  1  pulse; invalidate all tags (texture cache reset)
i_reqValid  in  1  CLUT lookup request
o_reqReady  out  1  request accepted when i_reqValid & o_reqReady
i_reqClut  in  15  CLUT address {Y[8:0], X16[5:0]}
i_req8BPP  in  1  1 = 8bpp palette (PKT_8BPP packets), 0 = 4bpp (1 packet)
o_doneValid  out  1  one-cycle pulse; palette for last request resident
o_doneSlot  out  SLOT_W  slot holding that palette
o_doneHit  out  1  1 = no load was needed
o_memReqValid  out  1  packet fetch request
i_memReqReady  in  1  fetch unit accepts request
o_memAdr  out  15  packet address
o_memBlock  out  4  packet index within palette (CLUT RAM write offset)
o_memSlot  out  SLOT_W  destination slot
i_pktDone  in  1  pulse; outstanding packet written to CLUT RAM
o_busy  out  1  state != IDLE

Behaviour:
Reset (i_nrst=0 at clock edge):
- All tags invalid; state IDLE; round-robin pointer 0.
- All outputs 0, except o_reqReady=1 from the first cycle after reset.
- Reset mid-load abandons the load with no further requests.

Tags, per slot: valid, clut[14:0], is8 (1 bit).

FSM states: IDLE, ISSUE, WAIT, DONE.

IDLE:
- o_reqReady=1.
- On accept, compare i_reqClut against all valid tags. A slot hits if clut matches and (is8 | !i_req8BPP); an 8bpp entry satisfies a 4bpp request.
- Hit: next cycle o_doneValid=1, o_doneSlot=matching slot (lowest index if several), o_doneHit=1; stay IDLE (DONE is bypassed). Back-to-back hits are sustainable at one per cycle.
- Miss, victim selection in priority order:
  1. A valid tag with the same clut and is8=0 (4bpp→8bpp upgrade) reuses that slot.
  2. Otherwise the lowest-index invalid slot.
  3. Otherwise the slot at the round-robin pointer, and the pointer increments modulo NUM_SLOTS.
- On a miss, latch the clut, depth and victim; clear the victim's valid bit; remaining = PKT_8BPP or 1; go to ISSUE.

ISSUE:
- o_memReqValid=1, o_memBlock=remaining-1.
- o_memAdr = {clut[14:6], (clut[5:0] + remaining-1) mod 64}; X wraps within the row and Y is never carried.
- On i_memReqReady go to WAIT.

WAIT:
- Hold until i_pktDone, then decrement remaining.
- If remaining is now 0, go to DONE; otherwise go to ISSUE.
- Exactly one packet is outstanding at any time.
- Packets are issued highest block first, down to block 0.

DONE:
- Write tag {valid=!flushSeen, clut, is8}.
- o_doneValid=1, o_doneSlot=victim, o_doneHit=0.
- Return to IDLE.

Flush:
- In IDLE, a flush clears all valid bits in the same cycle. A flush coinciding with a request accept takes priority, so the request is evaluated as a miss against empty tags.
- During ISSUE/WAIT, the load completes (the bus handshake is never dropped). flushSeen is set, so the tag is written invalid and o_doneValid still pulses.
- A flush also resets the round-robin pointer to 0.

Other rules:
- o_memReqValid, once raised, holds with stable address/block/slot until accepted.
- i_pktDone outside WAIT is ignored.
- The request payload is ignored when o_reqReady=0.

Test Plan:
- Reset, then request clut=0x0041 4bpp → 1 fetch adr=0x0041 blk=0 slot 0; after i_pktDone, done slot=0 hit=0. Repeat the same request → done next cycle, hit=1, slot 0, no fetch.
- Request clut=0x007E 8bpp → 16 fetches: blk15 adr=0x004D … blk1 adr=0x007F, blk0 adr=0x007E (X wrap stays in row 1); done hit=0.
- 4bpp clut=0x0100 loaded in slot 0, then 8bpp clut=0x0100 → miss reuses slot 0 with 16 packets. A later 4bpp 0x0100 request hits slot 0.
- Fill 4 slots with distinct cluts, then a 5th clut → victim slot 0 with pointer 1; a 6th clut → victim slot 1.
- i_flush during WAIT of an 8bpp load → all 16 packets still issued, done pulses, re-request misses. Flush coinciding with a request accept of a resident clut → miss, load issued.
- Hold i_memReqReady=0 for 5 cycles in ISSUE → o_memReqValid/adr stable. Deassert i_nrst in WAIT → next cycle o_memReqValid=0, o_busy=0, all tags invalid.
